inv_key_schedule: RTL

- Inverse AES-128 key expansion for the decryption datapath: given round key K(i) and round index i, produces round key K(i-1).
- Processes one 32-bit word per cycle, writing round-key words 3, 2, 1 and then 0.
- Shares the external S-box word lookup with the forward key schedule: exports the rotated word and takes back its substituted value.
- Lets the decryption controller walk from K10 down to K0 without storing the full expanded key.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_rcon_rom.sv | 21 ++
 rtl/inv_key_schedule.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: byte/word types, round constants,
// key-schedule FSM states and the row/column byte-layout helpers.
// A 128-bit key holds row r, column c at bits [8*(4r+c) +: 8]; a word is
// one column packed as {row3,row2,row1,row0}.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int RCON_ENTRIES = 10;

    localparam byte_t RCON [1:RCON_ENTRIES] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC3 = 3'd1,
        CALC2 = 3'd2,
        CALC1 = 3'd3,
        CALC0 = 3'd4
    } ks_state_t;

    // Gather column col of a key into a word, row 0 in the low byte.
    function automatic word_t get_word(input logic [127:0] key, input logic [1:0] col);
        word_t w;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            w[8*r +: 8] = key[8*(4*r + int'(col)) +: 8];
        end
        return w;
    endfunction

    // Scatter a word back into column col of a key, leaving other columns intact.
    function automatic logic [127:0] put_word(input logic [127:0] key, input logic [1:0] col,
                                              input word_t w);
        logic [127:0] k;
        k = key;
        for (int r = 0; r < 4; r++) begin
            k[8*(4*r + int'(col)) +: 8] = w[8*r +: 8];
        end
        return k;
    endfunction

endpackage

// File: rtl/aes_rcon_rom.sv
// AES round-constant lookup. Rounds 1..MAX_ROUND map to the RCON table;
// any other index (including 0) returns 8'h00.
module aes_rcon_rom #(
    parameter int MAX_ROUND = 10
) (
    input  logic [3:0] round,
    output logic [7:0] rcon
);
    import aes_pkg::*;

    // Table lookup; out-of-range rounds fall through to zero.
    always_comb begin
        rcon = 8'h00;
        for (int i = 1; i <= RCON_ENTRIES; i++) begin
            if ((i <= MAX_ROUND) && (round == 4'(i))) begin
                rcon = RCON[i];
            end
        end
    end

endmodule

// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key expansion: K(i) -> K(i-1), one column per cycle in the
// order 3, 2, 1, 0. Column 0 needs SubWord(RotWord(new column 3)), which is
// obtained from an external S-box shared with the forward schedule.
// Optional build macro INV_KEY_SCHED_ROUND_CHECK_EN adds an err output that
// rejects start requests carrying a round index outside 1..NR.
module inv_key_schedule #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    round,
    input  logic [KW-1:0] key_in,
    input  logic [31:0]   s_boxed_row,
    output logic [31:0]   sbox_word,
    output logic [KW-1:0] out_key,
    output logic          busy,
    output logic          done
`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
    ,
    output logic          err
`endif
);
    import aes_pkg::*;

    ks_state_t     state_reg, state_next;
    logic [KW-1:0] key_reg, key_next;
    logic [3:0]    round_reg, round_next;
    logic [KW-1:0] out_key_reg, out_key_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          accept;
    logic [7:0]    rcon;
    word_t         k0, k1, k2, k3;
    word_t         out_w3;

`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
    logic          err_reg, err_next;
    logic          round_ok;
    logic          reject;
`endif

    aes_rcon_rom #(
        .MAX_ROUND (NR)
    ) u_rcon (
        .round (round_reg),
        .rcon  (rcon)
    );

    assign k0     = get_word(key_reg, 2'd0);
    assign k1     = get_word(key_reg, 2'd1);
    assign k2     = get_word(key_reg, 2'd2);
    assign k3     = get_word(key_reg, 2'd3);
    assign out_w3 = get_word(out_key_reg, 2'd3);

    // RotWord of the freshly computed column 3; only consumed during CALC0.
    assign sbox_word = {out_w3[7:0], out_w3[31:8]};

`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
    assign round_ok = (round != 4'd0) && (int'(round) <= NR);
    assign accept   = start && round_ok;
    assign reject   = start && !round_ok;
`else
    assign accept   = start;
`endif

    // Next-state and datapath updates; each CALC state writes one column.
    always_comb begin
        state_next   = state_reg;
        key_next     = key_reg;
        round_next   = round_reg;
        out_key_next = out_key_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
        err_next     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    key_next   = key_in;
                    round_next = round;
                    busy_next  = 1'b1;
                    state_next = CALC3;
                end
`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
                if (reject) begin
                    err_next = 1'b1;
                end
`endif
            end
            CALC3: begin
                out_key_next = put_word(out_key_reg, 2'd3, k3 ^ k2);
                state_next   = CALC2;
            end
            CALC2: begin
                out_key_next = put_word(out_key_reg, 2'd2, k2 ^ k1);
                state_next   = CALC1;
            end
            CALC1: begin
                out_key_next = put_word(out_key_reg, 2'd1, k1 ^ k0);
                state_next   = CALC0;
            end
            CALC0: begin
                out_key_next = put_word(out_key_reg, 2'd0,
                                        k0 ^ s_boxed_row ^ {24'h0, rcon});
                done_next    = 1'b1;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            key_reg     <= '0;
            round_reg   <= '0;
            out_key_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
            err_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            key_reg     <= key_next;
            round_reg   <= round_next;
            out_key_reg <= out_key_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
            err_reg     <= err_next;
`endif
        end
    end

    assign out_key = out_key_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
`ifdef INV_KEY_SCHED_ROUND_CHECK_EN
    assign err     = err_reg;
`endif

endmodule
